// File: rtl/exec_div_pkg.sv
// Shared definitions for the execute-stage iterative divider: FSM states,
// default operand width and the {hi, lo} result field offsets.
package exec_div_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } divState_e;

    // Remainder lands in HI (upper WIDTH bits), quotient in LO (lower WIDTH bits).
    localparam int LO_OFS = 0;

    function automatic int hiOfs(input int width);
        return width;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract iteration: shifts the next dividend bit into
// the partial remainder and produces one quotient bit.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] remIn,
    input  logic [WIDTH-1:0] quoIn,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] remOut,
    output logic [WIDTH-1:0] quoOut
);

    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             fits;

    // quoIn doubles as the dividend shift register; its MSB feeds the remainder.
    assign shifted = {remIn, quoIn[WIDTH-1]};
    assign fits    = shifted >= {1'b0, divisor};
    assign diff    = shifted[WIDTH-1:0] - divisor;
    assign remOut  = fits ? diff : shifted[WIDTH-1:0];
    assign quoOut  = {quoIn[WIDTH-2:0], fits};

endmodule

// File: rtl/exec_div.sv
// Multi-cycle DIV/DIVU unit for the execute stage; stalls F/D/E while busy.
// Signed division is only built when EXEC_DIV_SIGNED_EN is defined.
module exec_div
    import exec_div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               signed_div,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               advance,
    input  logic               annul,
    output logic               stall_div,
    output logic               ready,
    output logic [2*WIDTH-1:0] result
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    divState_e        state, stateNext;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] divisor, rem, quo;
    logic [WIDTH-1:0] remNext, quoNext;
    logic [WIDTH-1:0] absA, absB, fixQ, fixR;

`ifdef EXEC_DIV_SIGNED_EN
    logic negQ, negR;
    logic aNeg, bNeg;

    assign aNeg = signed_div & a[WIDTH-1];
    assign bNeg = signed_div & b[WIDTH-1];
    assign absA = aNeg ? -a : a;
    assign absB = bNeg ? -b : b;
    // Truncation toward zero: quotient sign from operand XOR, remainder follows dividend.
    assign fixQ = negQ ? -quoNext : quoNext;
    assign fixR = negR ? -remNext : remNext;

    always_ff @(posedge clk) begin
        if (!rst) begin
            negQ <= 1'b0;
            negR <= 1'b0;
        end else if (state == IDLE && start && !annul) begin
            negQ <= aNeg ^ bNeg;
            negR <= aNeg;
        end
    end
`else
    logic unusedSignedDiv;

    assign unusedSignedDiv = signed_div;
    assign absA = a;
    assign absB = b;
    assign fixQ = quoNext;
    assign fixR = remNext;
`endif

    div_step #(.WIDTH(WIDTH)) uStep (
        .remIn  (rem),
        .quoIn  (quo),
        .divisor(divisor),
        .remOut (remNext),
        .quoOut (quoNext)
    );

    always_comb begin
        stateNext = state;
        if (annul) begin
            stateNext = IDLE;
        end else begin
            case (state)
                IDLE:    if (start)            stateNext = BUSY;
                BUSY:    if (cnt == LAST_STEP) stateNext = DONE;
                DONE:    if (advance)          stateNext = IDLE;
                default:                       stateNext = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            divisor <= '0;
            rem     <= '0;
            quo     <= '0;
            result  <= '0;
        end else begin
            state <= stateNext;
            case (state)
                IDLE: if (start && !annul) begin
                    divisor <= absB;
                    rem     <= '0;
                    quo     <= absA;
                    cnt     <= '0;
                end
                BUSY: if (!annul) begin
                    rem <= remNext;
                    quo <= quoNext;
                    cnt <= cnt + CNT_W'(1);
                    // Final step writes the corrected result straight from the step outputs.
                    if (cnt == LAST_STEP) begin
                        result[hiOfs(WIDTH) +: WIDTH] <= fixR;
                        result[LO_OFS +: WIDTH]       <= fixQ;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ready     = (state == DONE);
    assign stall_div = rst && ((state == IDLE && start && !annul) || state == BUSY);

endmodule

// File: tb/tb_exec_div.sv
// Directed bench for exec_div with a cycle-level transaction model and a
// per-cycle compare of stall_div, ready and result.
module tb_exec_div;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          signed_div = 1'b0;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic          advance = 1'b1;
    logic          annul = 1'b0;
    logic          stall_div;
    logic          ready;
    logic [2*W-1:0] result;

    int nCmp = 0;
    int nBad = 0;

    exec_div #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .signed_div(signed_div),
        .a         (a),
        .b         (b),
        .advance   (advance),
        .annul     (annul),
        .stall_div (stall_div),
        .ready     (ready),
        .result    (result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
        nCmp++;
        if (act !== exp) begin
            nBad++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural divide: {remainder, quotient}.
    function automatic logic [2*W-1:0] refDiv(input logic [W-1:0] x, input logic [W-1:0] y, input bit sd);
        bit     s;
        longint sx, sy, q, r;
`ifdef EXEC_DIV_SIGNED_EN
        s = sd;
`else
        s = 1'b0;
`endif
        if (y == 0) return (s && x[W-1]) ? {x, 32'd1} : {x, 32'hFFFF_FFFF};
        if (!s) return {x % y, x / y};
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        q  = sx / sy;
        r  = sx % sy;
        return {r[31:0], q[31:0]};
    endfunction

    // Transaction model: countdown of remaining iterations plus a "holding" flag.
    int             cd = 0;
    bit             done = 1'b0;
    logic [2*W-1:0] expResult = '0;
    logic [2*W-1:0] pending = '0;

    always @(posedge clk) begin
        if (!rst) begin
            cd = 0; done = 1'b0; expResult = '0;
        end else if (annul) begin
            cd = 0; done = 1'b0;
        end else if (done) begin
            if (advance) done = 1'b0;
        end else if (cd > 0) begin
            cd = cd - 1;
            if (cd == 0) begin
                done = 1'b1;
                expResult = pending;
            end
        end else if (start) begin
            cd = W;
            pending = refDiv(a, b, signed_div);
        end
    end

    always @(negedge clk) begin
        logic expStall;
        expStall = rst && ((cd > 0) || (!done && start && !annul));
        chk("stall_div", 64'(stall_div), 64'(expStall));
        chk("ready", 64'(ready), 64'(done));
        chk("result", result, expResult);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one divide and wait (bounded) for ready; start stays high while stalled.
    task automatic runOp(input logic [W-1:0] x, input logic [W-1:0] y, input bit sd, input bit adv,
                         output logic [2*W-1:0] res, output int lat, output int stalls);
        start = 1'b1; signed_div = sd; a = x; b = y; advance = adv;
        lat = 0; stalls = 0; res = '0;
        while (lat < 200) begin
            @(negedge clk);
            if (ready) begin
                res = result;
                break;
            end
            if (stall_div) stalls++;
            lat++;
        end
        if (lat >= 200) begin
            nBad++;
            $display("FAIL timeout: ready never rose for %h / %h", x, y);
        end
    endtask

    task automatic retire();
        tick();
        start = 1'b0;
        advance = 1'b1;
    endtask

    logic [2*W-1:0] res, held;
    int lat, stalls;
    bit sawReady;

    initial begin
        // Pin the model to hand-computed values.
        chk("ref 100/7", refDiv(32'd100, 32'd7, 1'b0), {32'd2, 32'd14});
        chk("ref 7/0", refDiv(32'd7, 32'd0, 1'b0), {32'd7, 32'hFFFF_FFFF});
        chk("ref 9/3", refDiv(32'd9, 32'd3, 1'b0), {32'd0, 32'd3});
`ifdef EXEC_DIV_SIGNED_EN
        chk("ref -7/2", refDiv(32'hFFFF_FFF9, 32'd2, 1'b1), {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        chk("ref min/-1", refDiv(32'h8000_0000, 32'hFFFF_FFFF, 1'b1), {32'd0, 32'h8000_0000});
`else
        chk("ref -7/2", refDiv(32'hFFFF_FFF9, 32'd2, 1'b1), {32'd1, 32'h7FFF_FFFC});
        chk("ref min/-1", refDiv(32'h8000_0000, 32'hFFFF_FFFF, 1'b1), {32'h8000_0000, 32'd0});
`endif

        repeat (2) tick();
        chk("reset result", result, '0);
        chk("reset ready", 64'(ready), 64'd0);
        rst = 1'b1;
        tick();

        // DIVU 100/7: latency and stall length.
        runOp(32'd100, 32'd7, 1'b0, 1'b1, res, lat, stalls);
        chk("100/7 result", res, {32'd2, 32'd14});
        chk("100/7 latency", 64'(lat), 64'd33);
        chk("100/7 stalls", 64'(stalls), 64'd33);
        retire();

        // DIV -7/2.
        runOp(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1, res, lat, stalls);
`ifdef EXEC_DIV_SIGNED_EN
        chk("-7/2 result", res, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
`else
        chk("-7/2 result", res, {32'd1, 32'h7FFF_FFFC});
`endif
        retire();

        // Divide by zero: normal latency.
        runOp(32'd7, 32'd0, 1'b0, 1'b1, res, lat, stalls);
        chk("7/0 result", res, {32'd7, 32'hFFFF_FFFF});
        chk("7/0 stalls", 64'(stalls), 64'd33);
        retire();

        // Most-negative / -1.
        runOp(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, res, lat, stalls);
`ifdef EXEC_DIV_SIGNED_EN
        chk("min/-1 result", res, {32'd0, 32'h8000_0000});
`else
        chk("min/-1 result", res, {32'h8000_0000, 32'd0});
`endif
        retire();

        // A few more mixed patterns, checked via the model only.
        runOp(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b1, res, lat, stalls);
        chk("max/1 result", res, {32'd0, 32'hFFFF_FFFF});
        retire();
        runOp(32'd7, 32'hFFFF_FFFE, 1'b1, 1'b1, res, lat, stalls);
        retire();
        runOp(32'hFFFF_FFF9, 32'd0, 1'b1, 1'b1, res, lat, stalls);
        retire();
        runOp(32'd12345678, 32'd1000, 1'b0, 1'b1, res, lat, stalls);
        chk("12345678/1000", res, {32'd678, 32'd12345});
        retire();
        held = res;

        // Annul at BUSY cycle 10.
        start = 1'b1; signed_div = 1'b0; a = 32'd100; b = 32'd7;
        tick();
        repeat (9) tick();
        annul = 1'b1; start = 1'b0;
        tick();
        annul = 1'b0;
        @(negedge clk);
        chk("annul stall", 64'(stall_div), 64'd0);
        chk("annul result", result, held);
        sawReady = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (ready) sawReady = 1'b1;
        end
        chk("annul no ready", 64'(sawReady), 64'd0);
        tick();

        // DONE hold with advance=0 and start still high.
        runOp(32'd50, 32'd5, 1'b0, 1'b0, res, lat, stalls);
        chk("50/5 result", res, {32'd0, 32'd10});
        repeat (3) begin
            @(negedge clk);
            chk("hold ready", 64'(ready), 64'd1);
            chk("hold result", result, res);
            chk("hold stall", 64'(stall_div), 64'd0);
        end
        tick();
        advance = 1'b1;
        tick();
        start = 1'b0;
        @(negedge clk);
        chk("advance ready", 64'(ready), 64'd0);
        tick();

        // Reset at BUSY cycle 5.
        start = 1'b1; signed_div = 1'b0; a = 32'd100; b = 32'd7;
        tick();
        repeat (4) tick();
        rst = 1'b0; start = 1'b0;
        tick();
        @(negedge clk);
        chk("rst ready", 64'(ready), 64'd0);
        chk("rst stall", 64'(stall_div), 64'd0);
        chk("rst result", result, '0);
        tick();
        rst = 1'b1;
        tick();
        runOp(32'd9, 32'd3, 1'b0, 1'b1, res, lat, stalls);
        chk("9/3 result", res, {32'd0, 32'd3});
        retire();
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", nCmp, nBad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
